// File: rtl/score_keeper_pkg.sv
// Shared game definitions: monster slot layout and seven-segment digit encoding.
package score_keeper_pkg;

  localparam int MONSTERS = 12;
  localparam int SLOT_W   = 19;

  // Field offsets inside one monster slot.
  localparam int PRES_BIT = 0;
  localparam int DIR_LSB  = 1;
  localparam int X_LSB    = 3;
  localparam int Y_LSB    = 11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd4_t;

  // Active-low cathodes {dp,g,f,e,d,c,b,a}; dp held off, non-decimal nibbles blank.
  function automatic logic [7:0] seg7_encode(input bcd_digit_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_inc4.sv
// Combinational 4-digit BCD increment; holds the value and flags saturation at 9999.
module bcd_inc4
  import score_keeper_pkg::*;
(
  input  logic [15:0] value,
  output logic [15:0] result,
  output logic        saturated
);

  logic carry;

  assign saturated = (value == 16'h9999);

  // Ripple the +1 through the digits, wrapping 9 to 0 with a carry.
  always_comb begin
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i*4 +: 4] == 4'd9) begin
          result[i*4 +: 4] = 4'd0;
        end else begin
          result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    if (saturated) result = value;
  end

endmodule

// File: rtl/score_keeper.sv
// Kill detection, BCD score / high score keeping and 8-digit seven-segment scan.
module score_keeper #(
  parameter int MONSTERS  = score_keeper_pkg::MONSTERS,
  parameter int SLOT_W    = score_keeper_pkg::SLOT_W,
  parameter int SCAN_BITS = 17,
  parameter int PEND_W    = 5
) (
  input  logic                       clk_game,
  input  logic                       rst_n,
  input  logic                       alive,
  input  logic [MONSTERS*SLOT_W-1:0] state_monsters,
  output logic [15:0]                score,
  output logic [15:0]                high_score,
  output logic                       new_record,
  output logic [7:0]                 seg,
  output logic [7:0]                 an
);

  import score_keeper_pkg::*;

  localparam int KW = $clog2(MONSTERS + 1);
  localparam int SW = ((PEND_W > KW) ? PEND_W : KW) + 1;
  localparam logic [SW-1:0] PEND_MAX = SW'((1 << PEND_W) - 1);

  logic                 alive_q;
  logic [MONSTERS-1:0]  pres_q;
  logic [MONSTERS-1:0]  pres_now;
  logic [MONSTERS-1:0]  kill;
  logic [KW-1:0]        kills;
  logic [PEND_W-1:0]    pending;
  logic [SW-1:0]        pend_sum;
  logic [PEND_W-1:0]    pend_next;
  logic                 dec;
  logic                 game_start;
  logic                 game_over;
  logic [15:0]          score_inc;
  logic                 score_sat;
  logic [SCAN_BITS-1:0] scan;
  logic [2:0]           sel;
  logic [31:0]          disp_word;
  logic [3:0]           nibble;
  logic                 unused_fields;

  // Direction and position fields are only of interest to other blocks.
  assign unused_fields = ^state_monsters;

  assign game_start = alive & ~alive_q;
  assign game_over  = ~alive & alive_q;
  assign dec        = (pending != '0);

  // Extract present bits and flag falls that happen during steady play.
  always_comb begin
    pres_now = '0;
    for (int i = 0; i < MONSTERS; i++) begin
      pres_now[i] = state_monsters[i*SLOT_W + PRES_BIT];
    end
    kill = pres_q & ~pres_now & {MONSTERS{alive & alive_q}};
  end

  // Count simultaneous kills and form the clamped pending update.
  always_comb begin
    kills = '0;
    for (int i = 0; i < MONSTERS; i++) begin
      kills = kills + KW'(kill[i]);
    end
    pend_sum  = SW'(pending) + SW'(kills) - SW'(dec);
    pend_next = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : pend_sum[PEND_W-1:0];
  end

  bcd_inc4 u_inc (
    .value     (score),
    .result    (score_inc),
    .saturated (score_sat)
  );

  // Edge registers for alive and the present bits.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
      pres_q  <= '0;
    end else begin
      alive_q <= alive;
      pres_q  <= pres_now;
    end
  end

  // Pending kills drain one per cycle; either alive edge discards them.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (game_start || game_over) begin
      pending <= '0;
    end else begin
      pending <= pend_next;
    end
  end

  // Score steps once per pending kill; a new game zeroes it.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
    end else if (game_start) begin
      score <= '0;
    end else if (dec && !score_sat) begin
      score <= score_inc;
    end
  end

  // At game over keep the better of score and high score, pulsing on a new record.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      high_score <= '0;
      new_record <= 1'b0;
    end else begin
      new_record <= 1'b0;
      if (game_over && (score > high_score)) begin
        high_score <= score;
        new_record <= 1'b1;
      end
    end
  end

  assign sel       = scan[SCAN_BITS-1 -: 3];
  assign disp_word = {high_score, score};
  assign nibble    = disp_word[{sel, 2'b00} +: 4];

  // Free-running refresh counter.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  // Register anode and cathodes together so they always describe the same digit.
  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFE;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(8'd1 << sel);
      seg <= seg7_encode(nibble);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: random and directed play against an integer score model.
module tb_score_keeper;
  import score_keeper_pkg::*;

  localparam int SB = 4;

  logic                       clk_game = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       alive = 1'b0;
  logic [MONSTERS*SLOT_W-1:0] state_monsters = '0;
  logic [15:0]                score;
  logic [15:0]                high_score;
  logic                       new_record;
  logic [7:0]                 seg;
  logic [7:0]                 an;

  score_keeper #(
    .MONSTERS (MONSTERS),
    .SLOT_W   (SLOT_W),
    .SCAN_BITS(SB),
    .PEND_W   (5)
  ) dut (
    .clk_game       (clk_game),
    .rst_n          (rst_n),
    .alive          (alive),
    .state_monsters (state_monsters),
    .score          (score),
    .high_score     (high_score),
    .new_record     (new_record),
    .seg            (seg),
    .an             (an)
  );

  always #5 clk_game = ~clk_game;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [15:0] exp_q[$];
  logic [15:0] hr_q[$];

  // Reference model state: plain decimal integers.
  int          m_s, m_hs, m_pend;
  logic        m_palive;
  logic [11:0] m_ppres;
  logic [11:0] pres;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int an_index(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a == ~(8'd1 << i)) return i;
    return -1;
  endfunction

  task automatic drive(input logic a, input logic [11:0] p);
    alive = a;
    pres  = p;
    for (int i = 0; i < MONSTERS; i++) begin
      state_monsters[i*SLOT_W +: SLOT_W] = SLOT_W'($urandom);
      state_monsters[i*SLOT_W + PRES_BIT] = p[i];
    end
  endtask

  task automatic reset_model();
    m_s = 0; m_hs = 0; m_pend = 0; m_palive = 1'b0; m_ppres = '0;
    exp_q.delete();
    hr_q.delete();
  endtask

  // One clock of game rules applied to what the bench drove.
  task automatic model_edge();
    int k, inc, s_old;
    logic start, over;
    k = 0;
    for (int i = 0; i < MONSTERS; i++)
      if (m_ppres[i] && !pres[i] && alive && m_palive) k++;
    start = alive && !m_palive;
    over  = !alive && m_palive;
    inc   = (m_pend > 0) ? 1 : 0;
    s_old = m_s;
    if (start) m_s = 0;
    else if (inc == 1 && m_s < 9999) m_s = m_s + 1;
    if (m_s != s_old) exp_q.push_back(to_bcd(m_s));
    if (over && s_old > m_hs) begin
      m_hs = s_old;
      hr_q.push_back(to_bcd(m_hs));
    end
    if (start || over) m_pend = 0;
    else begin
      m_pend = m_pend + k - inc;
      if (m_pend > 31) m_pend = 31;
    end
    m_palive = alive;
    m_ppres  = pres;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_game);
      model_edge();
      #1;
    end
  endtask

  // Deliver n kills at two per two cycles so nothing is lost to clamping.
  task automatic add_kills(input int n);
    int rem, k;
    rem = n;
    while (rem > 0) begin
      k = (rem > 2) ? 2 : rem;
      drive(1'b1, 12'hFFF);
      step(1);
      drive(1'b1, 12'hFFF >> k);
      step(1);
      rem -= k;
    end
    step(4);
  endtask

  // Monitor: every score change and every new_record pulse is matched against the model.
  initial begin : monitor
    logic [15:0] last_score;
    logic [15:0] e;
    last_score = '0;
    forever begin
      @(negedge clk_game);
      if (!rst_n) begin
        last_score = score;
      end else begin
        if (score !== last_score) begin
          if (exp_q.size() == 0) chk("score_unexpected_change", score, last_score);
          else begin
            e = exp_q.pop_front();
            chk("score_step", score, e);
          end
          last_score = score;
        end
        if (new_record === 1'b1) begin
          pulses++;
          if (hr_q.size() == 0) chk("new_record_unexpected", new_record, 0);
          else begin
            e = hr_q.pop_front();
            chk("new_record_high", high_score, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p0, prev_idx, run, idx, runs;
    logic [31:0] disp_exp;
    logic [3:0]  nib;
    logic        a;

    reset_model();
    drive(1'b0, 12'h000);
    #23;
    chk("reset_score", score, 16'h0000);
    chk("reset_high", high_score, 16'h0000);
    chk("reset_an", an, 8'hFE);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_new_record", new_record, 0);
    rst_n = 1'b1;
    step(1);

    drive(1'b1, 12'h000);
    step(1);
    chk("start_score", score, 16'h0000);

    // Single kill on slot 3, two-cycle latency.
    drive(1'b1, 12'h008);
    step(2);
    drive(1'b1, 12'h000);
    step(1);
    chk("single_kill_lat1", score, 16'h0000);
    step(1);
    chk("single_kill_lat2", score, 16'h0001);

    // Falls while not alive and on the rising edge are not scored.
    drive(1'b0, 12'hFFF); step(1);
    drive(1'b0, 12'h000); step(1);
    drive(1'b0, 12'hFFF); step(1);
    drive(1'b0, 12'h000); step(3);
    chk("dead_falls_ignored", score, 16'h0001);
    drive(1'b0, 12'hFFF); step(1);
    drive(1'b1, 12'h000); step(3);
    chk("start_clears", score, 16'h0000);

    // Slots 0,5,11 fall together, slot 2 one cycle later.
    drive(1'b1, 12'h825); step(2);
    drive(1'b1, 12'h004); step(1);
    drive(1'b1, 12'h000); step(6);
    chk("simultaneous_kills", score, 16'h0004);

    // Game over / start bookkeeping.
    add_kills(13);
    chk("score_17", score, 16'h0017);
    p0 = pulses;
    drive(1'b0, 12'h000); step(3);
    chk("high_17", high_score, 16'h0017);
    chk("pulse_17", pulses - p0, 1);
    drive(1'b1, 12'h000); step(2);
    add_kills(42);
    chk("score_42", score, 16'h0042);
    drive(1'b1, 12'hFFF); step(1);
    p0 = pulses;
    drive(1'b0, 12'h000); step(3);
    chk("high_42", high_score, 16'h0042);
    chk("pulse_42", pulses - p0, 1);
    drive(1'b1, 12'h000); step(2);
    chk("restart_score", score, 16'h0000);
    chk("restart_high", high_score, 16'h0042);
    add_kills(10);
    p0 = pulses;
    drive(1'b0, 12'h000); step(3);
    chk("high_kept", high_score, 16'h0042);
    chk("no_pulse", pulses - p0, 0);
    drive(1'b1, 12'h000); step(2);

    // Display scan with score 1234 and high score 5678.
    add_kills(5678);
    drive(1'b0, 12'h000); step(2);
    drive(1'b1, 12'h000); step(2);
    add_kills(1234);
    chk("disp_score", score, 16'h1234);
    chk("disp_high", high_score, 16'h5678);
    disp_exp = 32'h5678_1234;
    prev_idx = -1; run = 0; runs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_game);
      idx = an_index(an);
      chk("an_one_low", (idx >= 0) ? 1 : 0, 1);
      if (idx >= 0) begin
        nib = disp_exp[idx*4 +: 4];
        chk("seg_digit", seg, seg_tbl[nib]);
        if (prev_idx >= 0 && idx != prev_idx) begin
          chk("an_step", idx, (prev_idx + 1) % 8);
          if (runs > 0) chk("an_dwell", run, 2);
          runs++;
          run = 0;
        end
        run++;
        prev_idx = idx;
      end
    end
    @(posedge clk_game);
    #1;

    // BCD carry and saturation.
    drive(1'b0, 12'h000); step(2);
    drive(1'b1, 12'h000); step(2);
    add_kills(999);
    chk("bcd_0999", score, 16'h0999);
    add_kills(1);
    chk("bcd_1000", score, 16'h1000);
    add_kills(8999);
    chk("bcd_9999", score, 16'h9999);
    add_kills(3);
    step(5);
    chk("bcd_saturate", score, 16'h9999);

    // Random play, including alive toggles and pending clamping.
    a = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) a = ~a;
      drive(a, 12'($urandom));
      step(1);
    end
    drive(1'b1, pres); step(1);
    step(40);
    chk("score_queue_drained", exp_q.size(), 0);
    chk("record_queue_drained", hr_q.size(), 0);
    chk("final_score", score, to_bcd(m_s));
    chk("final_high", high_score, to_bcd(m_hs));

    // Asynchronous reset away from a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_score", score, 16'h0000);
    chk("async_reset_high", high_score, 16'h0000);
    chk("async_reset_an", an, 8'hFE);
    chk("async_reset_seg", seg, 8'hFF);
    chk("async_reset_new_record", new_record, 0);
    reset_model();
    #20;
    rst_n = 1'b1;
    step(2);
    chk("post_reset_score", score, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream consumer of the game state machine; samples the packed monster state vector and the game-alive flag on clk_game.
- Detects monster kills and accumulates a 4-digit BCD score.
- Latches a BCD high score at game over.
- Multiplexes both values onto an 8-digit seven-segment display: high score on the left four digits, score on the right four.

Parameters:
- MONSTERS, 12, number of monster slots in state_monsters.
- SLOT_W, 19, bits per slot: [0] present, [2:1] direction, [10:3] x, [18:11] y.
- SCAN_BITS, 17, width of the display refresh counter; the digit select is its top 3 bits.
- PEND_W, 5, width of the pending-kill counter.

Ports:
- clk_game  in  1  game clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alive  in  1  game-running flag from the state machine.
- state_monsters  in  MONSTERS*SLOT_W  packed monster slots.
- score  out  16  current score, 4 BCD digits, digit 3 in [15:12].
- high_score  out  16  best score, 4 BCD digits.
- new_record  out  1  one-cycle pulse when high_score is updated.
- seg  out  8  cathodes, active-low; bit order {dp,g,f,e,d,c,b,a}; dp is always off (1).
- an  out  8  anodes, active-low, exactly one low; an[0] is the rightmost digit.

Behaviour:
- Reset (rst_n=0, asynchronous): score, high_score, pending, scan counter and all edge registers clear; new_record=0; an=8'hFE; seg=blank (8'hFF).
- Registers
  - alive_q: previous alive.
  - pres_q[MONSTERS-1:0]: previous present bits.
- Kill detection
  - kill[i] = pres_q[i] & ~state_monsters[i*SLOT_W] & alive & alive_q.
  - Falls while alive is low or on the alive edge cycles do not count, so the state machine clearing all slots at game over is never scored.
  - kills = popcount(kill), range 0..12.
- Pending counter
  - pending <= min(pending + kills - dec, 2^PEND_W-1), where dec = (pending != 0).
  - The add and the decrement apply in the same cycle.
- Score
  - Each cycle pending != 0, score increments by one in BCD: each digit carries 9->0 into the next.
  - Score saturates at 16'h9999. Pending still drains; further increments are dropped.
  - Latency: a single kill appears in score 2 cycles after the present bit falls (1 cycle for detection register, 1 cycle for the increment).
- Game start (alive 0->1, alive & ~alive_q)
  - score <= 0 and pending <= 0.
  - This overrides any increment in the same cycle.
- Game over (alive 1->0)
  - The cycle after the falling edge, if score > high_score (unsigned compare of the BCD words, valid for BCD), high_score <= score and new_record pulses for 1 cycle.
  - Pending kills left at game over are discarded. Pending clears on the falling edge.
- Reset mid-game: everything clears. high_score is lost, because it is not retained across rst_n.
- Display
  - scan counter free-runs.
  - sel = scan[SCAN_BITS-1 -: 3].
  - Digits 0-3 show score nibbles 0-3; digits 4-7 show high_score nibbles 0-3.
  - an = ~(1<<sel).
  - seg is registered one cycle after sel, with an registered alongside so the two stay aligned.
  - Nibbles A-F (never expected) display blank.
- Wrap: the scan counter wraps modulo 2^SCAN_BITS, with no glitch on an.

Decomposition:
- Shared game package holds:
  - MONSTERS and SLOT_W, also used by the state machine and renderer.
  - Slot field offsets (PRES_BIT=0, DIR_LSB=1, X_LSB=3, Y_LSB=11).
  - The 7-seg digit encoding function.
- One sub-module, bcd_inc4: combinational 4-digit BCD +1 with saturate flag. It is instantiated once and is reusable by a future timer block.

Test Plan:
- Reset: rst_n low mid-scan -> score=0000, high_score=0000, an=FE, seg=FF immediately (asynchronously), no new_record.
- Single kill: alive=1 steady, slot 3 present 1->0 -> score=0001 exactly 2 cycles later; slots falling while alive=0 -> score unchanged.
- Simultaneous kills: slots 0,5,11 fall in the same cycle, then slot 2 one cycle later -> score reaches 0004 over consecutive cycles and pending returns to 0.
- BCD carry and saturate: preload via 999 kills -> 0999, next kill -> 1000; drive to 9999 then 3 kills -> stays 9999, pending drains to 0.
- Game over/start: score 0042, high 0017, alive falls with all slots clearing -> no extra kills, high_score=0042 with one new_record pulse; alive rises -> score=0000, high_score=0042. Repeat with score 0010 -> high_score stays 0042, no pulse.
- Display: SCAN_BITS=4, score 1234, high 5678 -> an steps FE,FD,...,7F, with seg encoding 4,3,2,1,8,7,6,5 aligned to an each slot.
